// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic single-beat initiator: one LSU load/store in, one bus cycle out,
// one response pulse back with extended read data or an error flag.
module wb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [3:0]        SEL_O,
  output logic [31:0]       DAT_O,
  input  logic [31:0]       DAT_I,
  input  logic              ACK_I,
  input  logic              ERR_I
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state, state_d;
  logic [15:0]       cnt;
  logic              cyc_q, we_q, signed_q, err_q;
  logic [1:0]        size_q, lane_q;
  logic [ADDR_W-1:0] adr_q;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       dat_q, dat_d, rdata_q, load_data;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic              misaligned, timeout_hit;

  assign misaligned  = (req_size == 2'd3) ||
                       (req_size == 2'd1 && req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

  // Lane steering for the request about to be accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_d = 4'b1111;
    dat_d = req_wdata;
    case (req_size)
      2'd0: begin
        sel_d = 4'b0001 << req_addr[1:0];
        dat_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        sel_d = 4'b0011 << req_addr[1:0];
        dat_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Read lane selection and zero/sign extension of the latched load.
  always_comb begin
    byte_lane = DAT_I[{lane_q, 3'b000} +: 8];
    half_lane = DAT_I[{lane_q[1], 4'b0000} +: 16];
    load_data = DAT_I;
    case (size_q)
      2'd0:    load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'd1:    load_data = {{16{signed_q & half_lane[15]}}, half_lane};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (req_valid) state_d = misaligned ? RESP : BUS;
      BUS:  if (ACK_I || ERR_I || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      lane_q   <= 2'd0;
      adr_q    <= '0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
      rdata_q  <= 32'd0;
      cnt      <= 16'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          signed_q <= req_signed;
          size_q   <= req_size;
          lane_q   <= req_addr[1:0];
          adr_q    <= {req_addr[ADDR_W-1:2], 2'b00};
          sel_q    <= sel_d;
          dat_q    <= dat_d;
          cnt      <= 16'd0;
          err_q    <= misaligned;
          rdata_q  <= 32'd0;
          cyc_q    <= !misaligned;
        end
        BUS: begin
          // ERR has priority over a simultaneous ACK.
          if (ERR_I) begin
            cyc_q <= 1'b0;
            err_q <= 1'b1;
          end else if (ACK_I) begin
            cyc_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : load_data;
          end else if (timeout_hit) begin
            cyc_q <= 1'b0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_data  = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid & err_q;
  assign CYC_O      = cyc_q;
  assign STB_O      = cyc_q;
  assign WE_O       = we_q;
  assign ADR_O      = adr_q;
  assign SEL_O      = sel_q;
  assign DAT_O      = dat_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: directed cases plus random traffic against a
// transaction-level reference model and a configurable Wishbone slave.
module tb_wb_master_bridge;
  localparam int ADDR_W = 32;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              CYC_O, STB_O, WE_O;
  logic [ADDR_W-1:0] ADR_O;
  logic [3:0]        SEL_O;
  logic [31:0]       DAT_O;
  logic [31:0]       DAT_I = 32'd0;
  logic              ACK_I = 1'b0;
  logic              ERR_I = 1'b0;

  wb_master_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .SEL_O(SEL_O),
    .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave behaviour: kind 0 = ACK, 1 = ERR, 2 = ACK+ERR, 3 = never answers.
  int          sl_kind  = 0;
  int          sl_delay = 0;
  logic [31:0] sl_rdata = 32'd0;
  int          sl_cnt   = 0;

  always @(negedge clk) begin
    if (CYC_O === 1'b1 && STB_O === 1'b1) begin
      if (sl_kind != 3 && sl_cnt == sl_delay) begin
        ACK_I = (sl_kind != 1);
        ERR_I = (sl_kind != 0);
        DAT_I = sl_rdata;
      end else begin
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        DAT_I = $urandom;
      end
      sl_cnt++;
    end else begin
      ACK_I  = 1'b0;
      ERR_I  = 1'b0;
      sl_cnt = 0;
    end
  end

  // Bus monitor: strobe counts, first-beat capture, stability of held outputs.
  int          stb_cycles = 0, stb_rises = 0, resp_total = 0;
  logic        stb_prev = 1'b0;
  bit          unstable = 1'b0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  always @(negedge clk) begin
    if (CYC_O !== STB_O) unstable = 1'b1;
    if (STB_O === 1'b1) begin
      if (!stb_prev) begin
        stb_rises++;
        cap_adr = ADR_O; cap_dat = DAT_O; cap_sel = SEL_O; cap_we = WE_O;
      end else if (cap_adr !== ADR_O || cap_dat !== DAT_O || cap_sel !== SEL_O || cap_we !== WE_O) begin
        unstable = 1'b1;
      end
      stb_cycles++;
    end
    stb_prev = STB_O;
    if (resp_valid === 1'b1) resp_total++;
  end

  int resp_expected = 0;

  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata, input int kind,
                        input int delay, input logic [31:0] rdata);
    int          guard, lat, a, exp_stb;
    bit          got, rej, answered, exp_err;
    logic [31:0] mask, exp_data, exp_dat, rd, shifted;
    logic [3:0]  exp_sel;
    logic        re;

    // Reference model of the whole transaction.
    a   = int'(addr % 4);
    rej = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a != 0);
    case (size)
      2'd0:    begin mask = 32'hFF;   exp_sel = 4'(1 << a); exp_dat = 32'(wdata[7:0]) * 32'h0101_0101; end
      2'd1:    begin mask = 32'hFFFF; exp_sel = 4'(3 << a); exp_dat = 32'(wdata[15:0]) * 32'h0001_0001; end
      default: begin mask = 32'hFFFF_FFFF; exp_sel = 4'hF; exp_dat = wdata; end
    endcase
    shifted  = (rdata >> (8 * a)) & mask;
    if (sgn && size < 2'd2 && (shifted & ((mask >> 1) + 32'd1)) != 0) shifted = shifted | ~mask;
    answered = (kind != 3) && (delay < TO);
    exp_stb  = rej ? 0 : (answered ? delay + 1 : TO);
    exp_err  = rej || !answered || kind != 0;
    exp_data = (exp_err || we) ? 32'd0 : shifted;

    guard = 0;
    @(posedge clk); #1;
    while (!req_ready && guard < 10) begin @(posedge clk); #1; guard++; end
    check("ready_wait", 32'(req_ready), 32'd1);
    sl_kind = kind; sl_delay = delay; sl_rdata = rdata;
    stb_cycles = 0; stb_rises = 0; unstable = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_we = we; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_expected++;

    lat = 0; got = 1'b0; rd = 32'd0; re = 1'b0;
    while (!got && lat < TO + 6) begin
      @(negedge clk); #1;
      lat++;
      if (resp_valid) begin got = 1'b1; rd = resp_data; re = resp_err; end
    end
    check("resp_arrived", 32'(got), 32'd1);
    check("resp_data", rd, exp_data);
    check("resp_err", 32'(re), 32'(exp_err));
    check("resp_latency", 32'(lat), 32'(exp_stb + 1));
    check("stb_cycles", 32'(stb_cycles), 32'(exp_stb));
    check("stb_count", 32'(stb_rises), rej ? 32'd0 : 32'd1);
    check("bus_stable", 32'(unstable), 32'd0);
    if (!rej) begin
      check("adr_o", cap_adr, addr & 32'hFFFF_FFFC);
      check("sel_o", 32'(cap_sel), 32'(exp_sel));
      check("we_o", 32'(cap_we), 32'(we));
      if (we) check("dat_o", cap_dat, exp_dat);
    end
    @(negedge clk); #1;
    check("resp_pulse_len", 32'(resp_valid), 32'd0);
    check("idle_resp_data", resp_data | 32'(resp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int resp_snap;
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_cyc_stb", {30'd0, CYC_O, STB_O}, 32'd0);
    check("rst_we_sel", {27'd0, WE_O, SEL_O}, 32'd0);
    check("rst_adr", ADR_O, 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    check("rst_resp", {31'd0, resp_valid} | resp_data | 32'(resp_err), 32'd0);
    #22 rst = 1'b1;

    // Directed cases.
    do_txn(32'h8,   1'b0, 2'd2, 1'b0, 32'd0,        0, 2, 32'hDEAD_BEEF);
    do_txn(32'h103, 1'b0, 2'd0, 1'b1, 32'd0,        0, 0, 32'h8012_3456);
    do_txn(32'h103, 1'b0, 2'd0, 1'b0, 32'd0,        0, 0, 32'h8012_3456);
    do_txn(32'h0C2, 1'b1, 2'd1, 1'b0, 32'h1234_ABCD, 0, 1, 32'hFFFF_FFFF);
    do_txn(32'h6,   1'b0, 2'd2, 1'b0, 32'd0,        0, 0, 32'h1111_1111);
    do_txn(32'h41,  1'b0, 2'd1, 1'b0, 32'd0,        0, 0, 32'h1111_1111);
    do_txn(32'h40,  1'b0, 2'd3, 1'b0, 32'd0,        0, 0, 32'h1111_1111);
    do_txn(32'h20,  1'b0, 2'd2, 1'b0, 32'd0,        3, 0, 32'h2222_2222);
    do_txn(32'h24,  1'b0, 2'd2, 1'b0, 32'd0,        2, 1, 32'h3333_3333);
    do_txn(32'h26,  1'b0, 2'd1, 1'b1, 32'd0,        1, 0, 32'h8000_0000);
    do_txn(32'h2A,  1'b0, 2'd1, 1'b1, 32'd0,        0, 3, 32'h9ABC_0000);

    // Reset while a bus cycle is outstanding.
    @(posedge clk); #1;
    sl_kind = 3; sl_delay = 0;
    req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_cyc", 32'(CYC_O), 32'd1);
    resp_snap = resp_total;
    rst = 1'b0;
    #1;
    check("midrst_cyc_stb", {30'd0, CYC_O, STB_O}, 32'd0);
    check("midrst_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_ready", 32'(req_ready), 32'd1);
    check("midrst_no_resp", 32'(resp_total), 32'(resp_snap));

    // Back-to-back after reset.
    do_txn(32'h200, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 0, 32'd0);
    do_txn(32'h205, 1'b0, 2'd0, 1'b1, 32'd0,         0, 0, 32'h0000_F700);
    do_txn(32'h20A, 1'b1, 2'd1, 1'b0, 32'h0000_5A5A, 0, 1, 32'd0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      int          kr, kind;
      logic [31:0] addr;
      kr   = int'($urandom_range(0, 7));
      kind = (kr < 5) ? 0 : kr - 4;
      addr = $urandom & 32'h0000_FFFF;
      do_txn(addr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, kind, int'($urandom_range(0, 5)), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    check("resp_total", 32'(resp_total), 32'(resp_expected));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
